// File: rtl/m_pipe_reg.sv
// Execute-to-memory pipeline register chain (DEPTH stages) with stall, bubble injection,
// sticky fault freeze and a saturating count of injected bubbles.
module m_pipe_reg #(
  parameter int              WORD_W       = 64,
  parameter int              REG_W        = 4,
  parameter int              DEPTH        = 1,
  parameter int              CNT_W        = 16,
  parameter logic [REG_W-1:0] BUBBLE_ICODE = 4'h1,
  parameter logic [1:0]      AOK          = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        e_stat,
  input  logic [REG_W-1:0]  e_icode,
  input  logic              e_Cnd,
  input  logic [WORD_W-1:0] e_valE,
  input  logic [WORD_W-1:0] e_valA,
  input  logic [WORD_W-1:0] e_valB,
  input  logic [REG_W-1:0]  e_dstE,
  input  logic [REG_W-1:0]  e_dstM,
  input  logic              M_stall,
  input  logic              M_bubble,
  output logic [1:0]        M_stat,
  output logic [REG_W-1:0]  M_icode,
  output logic              M_Cnd,
  output logic [WORD_W-1:0] M_valE,
  output logic [WORD_W-1:0] M_valA,
  output logic [WORD_W-1:0] M_valB,
  output logic [REG_W-1:0]  M_dstE,
  output logic [REG_W-1:0]  M_dstM,
  output logic              M_valid,
  output logic              M_fault,
  output logic [CNT_W-1:0]  M_bubble_cnt
);

  typedef struct packed {
    logic [1:0]        stat;
    logic [REG_W-1:0]  icode;
    logic              cnd;
    logic [WORD_W-1:0] val_e;
    logic [WORD_W-1:0] val_a;
    logic [WORD_W-1:0] val_b;
    logic [REG_W-1:0]  dst_e;
    logic [REG_W-1:0]  dst_m;
    logic              valid;
  } stage_t;

  stage_t           stage_reg [DEPTH];
  stage_t           bubble_entry;
  stage_t           input_entry;
  logic             fault_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             hold;
  logic             advance;
  logic             inject;

  assign bubble_entry = '{stat: AOK, icode: BUBBLE_ICODE, cnd: 1'b0,
                          val_e: '0, val_a: '0, val_b: '0,
                          dst_e: '1, dst_m: '1, valid: 1'b0};

  assign input_entry = '{stat: e_stat, icode: e_icode, cnd: e_Cnd,
                         val_e: e_valE, val_a: e_valA, val_b: e_valB,
                         dst_e: e_dstE, dst_m: e_dstM, valid: 1'b1};

  // Freeze also on the edge that first sees a bad status, so the faulting entry never leaves.
  assign hold    = fault_reg || (stage_reg[DEPTH-1].stat != AOK);
  assign advance = !hold && !M_stall;
  assign inject  = advance && M_bubble;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_reg[i] <= bubble_entry;
    end else if (advance) begin
      stage_reg[0] <= M_bubble ? bubble_entry : input_entry;
      for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_reg <= 1'b0;
    end else if (stage_reg[DEPTH-1].stat != AOK) begin
      fault_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (inject && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign M_stat       = stage_reg[DEPTH-1].stat;
  assign M_icode      = stage_reg[DEPTH-1].icode;
  assign M_Cnd        = stage_reg[DEPTH-1].cnd;
  assign M_valE       = stage_reg[DEPTH-1].val_e;
  assign M_valA       = stage_reg[DEPTH-1].val_a;
  assign M_valB       = stage_reg[DEPTH-1].val_b;
  assign M_dstE       = stage_reg[DEPTH-1].dst_e;
  assign M_dstM       = stage_reg[DEPTH-1].dst_m;
  assign M_valid      = stage_reg[DEPTH-1].valid;
  assign M_fault      = fault_reg;
  assign M_bubble_cnt = cnt_reg;

endmodule

// File: tb/tb_m_pipe_reg.sv
// Directed bench: three m_pipe_reg instances (DEPTH 1/2/3) share one stimulus; a vector table
// drives the DEPTH=1 copy, hand sequences cover latency, stall, fault freeze and saturation.
module tb_m_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  e_stat;
  logic [3:0]  e_icode;
  logic        e_cnd;
  logic [63:0] e_val_e, e_val_a, e_val_b;
  logic [3:0]  e_dst_e, e_dst_m;
  logic        m_stall, m_bubble;

  logic [1:0]  d1_stat, d2_stat, d3_stat;
  logic [3:0]  d1_icode, d2_icode, d3_icode;
  logic        d1_cnd, d2_cnd, d3_cnd;
  logic [63:0] d1_val_e, d2_val_e, d3_val_e;
  logic [63:0] d1_val_a, d2_val_a, d3_val_a;
  logic [63:0] d1_val_b, d2_val_b, d3_val_b;
  logic [3:0]  d1_dst_e, d2_dst_e, d3_dst_e;
  logic [3:0]  d1_dst_m, d2_dst_m, d3_dst_m;
  logic        d1_valid, d2_valid, d3_valid;
  logic        d1_fault, d2_fault, d3_fault;
  logic [15:0] d1_cnt, d2_cnt;
  logic [3:0]  d3_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  m_pipe_reg #(.DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_cnd),
    .e_valE(e_val_e), .e_valA(e_val_a), .e_valB(e_val_b), .e_dstE(e_dst_e), .e_dstM(e_dst_m),
    .M_stall(m_stall), .M_bubble(m_bubble),
    .M_stat(d1_stat), .M_icode(d1_icode), .M_Cnd(d1_cnd), .M_valE(d1_val_e), .M_valA(d1_val_a),
    .M_valB(d1_val_b), .M_dstE(d1_dst_e), .M_dstM(d1_dst_m), .M_valid(d1_valid),
    .M_fault(d1_fault), .M_bubble_cnt(d1_cnt));

  m_pipe_reg #(.DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_cnd),
    .e_valE(e_val_e), .e_valA(e_val_a), .e_valB(e_val_b), .e_dstE(e_dst_e), .e_dstM(e_dst_m),
    .M_stall(m_stall), .M_bubble(m_bubble),
    .M_stat(d2_stat), .M_icode(d2_icode), .M_Cnd(d2_cnd), .M_valE(d2_val_e), .M_valA(d2_val_a),
    .M_valB(d2_val_b), .M_dstE(d2_dst_e), .M_dstM(d2_dst_m), .M_valid(d2_valid),
    .M_fault(d2_fault), .M_bubble_cnt(d2_cnt));

  m_pipe_reg #(.DEPTH(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_cnd),
    .e_valE(e_val_e), .e_valA(e_val_a), .e_valB(e_val_b), .e_dstE(e_dst_e), .e_dstM(e_dst_m),
    .M_stall(m_stall), .M_bubble(m_bubble),
    .M_stat(d3_stat), .M_icode(d3_icode), .M_Cnd(d3_cnd), .M_valE(d3_val_e), .M_valA(d3_val_a),
    .M_valB(d3_val_b), .M_dstE(d3_dst_e), .M_dstM(d3_dst_m), .M_valid(d3_valid),
    .M_fault(d3_fault), .M_bubble_cnt(d3_cnt));

  typedef struct {
    logic        stall;
    logic        bubble;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [3:0]  dst_e;
    logic [3:0]  x_icode;
    logic [63:0] x_val_e;
    logic [3:0]  x_dst_e;
    logic        x_valid;
    logic [15:0] x_cnt;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] stat, input logic [3:0] icode, input logic [63:0] val_e,
                       input logic [3:0] dst_e, input logic stall, input logic bubble);
    e_stat   = stat;
    e_icode  = icode;
    e_cnd    = icode[0];
    e_val_e  = val_e;
    e_val_a  = val_e + 64'd1;
    e_val_b  = val_e + 64'd2;
    e_dst_e  = dst_e;
    e_dst_m  = ~dst_e;
    m_stall  = stall;
    m_bubble = bubble;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // stall, bubble, icode, valE, dstE  ->  icode, valE, dstE, valid, bubble count
    tbl[0] = '{1'b0, 1'b0, 4'h6, 64'h10,   4'h3, 4'h6, 64'h10,   4'h3, 1'b1, 16'd0};
    tbl[1] = '{1'b0, 1'b0, 4'h2, 64'h20,   4'h5, 4'h2, 64'h20,   4'h5, 1'b1, 16'd0};
    tbl[2] = '{1'b1, 1'b0, 4'h7, 64'h70,   4'h7, 4'h2, 64'h20,   4'h5, 1'b1, 16'd0};
    tbl[3] = '{1'b0, 1'b1, 4'h7, 64'h70,   4'h7, 4'h1, 64'h0,    4'hF, 1'b0, 16'd1};
    tbl[4] = '{1'b1, 1'b1, 4'h9, 64'h90,   4'h9, 4'h1, 64'h0,    4'hF, 1'b0, 16'd1};
    tbl[5] = '{1'b0, 1'b0, 4'h8, 64'hAA,   4'h0, 4'h8, 64'hAA,   4'h0, 1'b1, 16'd1};
    tbl[6] = '{1'b0, 1'b1, 4'hB, 64'hBB,   4'hB, 4'h1, 64'h0,    4'hF, 1'b0, 16'd2};
    tbl[7] = '{1'b0, 1'b0, 4'h3, 64'h1234, 4'h9, 4'h3, 64'h1234, 4'h9, 1'b1, 16'd2};

    drive(2'b00, 4'h0, 64'h0, 4'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    check("reset stat",   64'(d1_stat),  64'h0);
    check("reset icode",  64'(d1_icode), 64'h1);
    check("reset cnd",    64'(d1_cnd),   64'h0);
    check("reset valE",   d1_val_e,      64'h0);
    check("reset valA",   d1_val_a,      64'h0);
    check("reset dstE",   64'(d1_dst_e), 64'hF);
    check("reset dstM",   64'(d1_dst_m), 64'hF);
    check("reset valid",  64'(d1_valid), 64'h0);
    check("reset fault",  64'(d1_fault), 64'h0);
    check("reset cnt",    64'(d1_cnt),   64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table on the DEPTH=1 instance.
    for (int i = 0; i < 8; i++) begin
      drive(2'b00, tbl[i].icode, tbl[i].val_e, tbl[i].dst_e, tbl[i].stall, tbl[i].bubble);
      step();
      check($sformatf("vec%0d icode", i), 64'(d1_icode), 64'(tbl[i].x_icode));
      check($sformatf("vec%0d valE",  i), d1_val_e,      tbl[i].x_val_e);
      check($sformatf("vec%0d dstE",  i), 64'(d1_dst_e), 64'(tbl[i].x_dst_e));
      check($sformatf("vec%0d valid", i), 64'(d1_valid), 64'(tbl[i].x_valid));
      check($sformatf("vec%0d cnt",   i), 64'(d1_cnt),   64'(tbl[i].x_cnt));
    end
    check("vec7 valA", d1_val_a, 64'h1235);
    check("vec7 dstM", 64'(d1_dst_m), 64'h6);

    // DEPTH=3 latency with a stalled edge: icodes 2,3,4 emerge in order.
    do_reset();
    begin
      logic [3:0] in_icode  [7];
      logic       in_stall  [7];
      logic [3:0] exp_icode [7];
      logic       exp_valid [7];
      in_icode  = '{4'h2, 4'h3, 4'h3, 4'h4, 4'h9, 4'h9, 4'h9};
      in_stall  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      exp_icode = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h9};
      exp_valid = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 7; i++) begin
        drive(2'b00, in_icode[i], 64'(in_icode[i]), 4'h2, in_stall[i], 1'b0);
        step();
        check($sformatf("d3 order e%0d icode", i + 1), 64'(d3_icode), 64'(exp_icode[i]));
        check($sformatf("d3 order e%0d valid", i + 1), 64'(d3_valid), 64'(exp_valid[i]));
      end
    end

    // DEPTH=3 bubble pulse between two instructions, then a stalled bubble.
    do_reset();
    drive(2'b00, 4'h5, 64'h55, 4'h4, 1'b0, 1'b0); step();
    drive(2'b00, 4'h0, 64'h0,  4'h0, 1'b0, 1'b1); step();
    drive(2'b00, 4'h6, 64'h66, 4'h4, 1'b0, 1'b0); step();
    check("d3 bub pre icode", 64'(d3_icode), 64'h5);
    step();
    check("d3 bub icode", 64'(d3_icode), 64'h1);
    check("d3 bub dstE",  64'(d3_dst_e), 64'hF);
    check("d3 bub dstM",  64'(d3_dst_m), 64'hF);
    check("d3 bub valid", 64'(d3_valid), 64'h0);
    check("d3 bub cnt",   64'(d3_cnt),   64'h1);
    drive(2'b00, 4'h7, 64'h77, 4'h4, 1'b1, 1'b1); step();
    check("d3 stall-bub cnt",   64'(d3_cnt),   64'h1);
    check("d3 stall-bub icode", 64'(d3_icode), 64'h1);
    drive(2'b00, 4'h7, 64'h77, 4'h4, 1'b0, 1'b0); step();
    check("d3 post icode", 64'(d3_icode), 64'h6);

    // DEPTH=2 fault: bad status reaches output, fault latches, outputs freeze.
    do_reset();
    drive(2'b01, 4'h7, 64'h77, 4'h3, 1'b0, 1'b0); step();
    drive(2'b00, 4'h8, 64'h88, 4'h4, 1'b0, 1'b0); step();
    check("d2 fault stat",  64'(d2_stat),  64'h1);
    check("d2 fault icode", 64'(d2_icode), 64'h7);
    check("d2 fault pre",   64'(d2_fault), 64'h0);
    drive(2'b00, 4'h9, 64'h99, 4'h5, 1'b0, 1'b0); step();
    check("d2 fault set", 64'(d2_fault), 64'h1);
    for (int i = 0; i < 10; i++) begin
      drive(2'b00, 4'(i + 2), 64'(i + 256), 4'(i), i[0], i[1]);
      step();
      check($sformatf("d2 frozen%0d icode", i), 64'(d2_icode), 64'h7);
      check($sformatf("d2 frozen%0d valE",  i), d2_val_e,      64'h77);
      check($sformatf("d2 frozen%0d fault", i), 64'(d2_fault), 64'h1);
      check($sformatf("d2 frozen%0d cnt",   i), 64'(d2_cnt),   64'h0);
    end

    // Asynchronous reset between edges while faulted.
    #2;
    rst = 1'b1;
    #1;
    check("async fault", 64'(d2_fault), 64'h0);
    check("async valid", 64'(d2_valid), 64'h0);
    check("async cnt",   64'(d2_cnt),   64'h0);
    check("async icode", 64'(d2_icode), 64'h1);
    check("async stat",  64'(d2_stat),  64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 4'h4, 64'h44, 4'h2, 1'b1, 1'b1);
    drive(2'b00, 4'h4, 64'h44, 4'h2, 1'b0, 1'b0);
    step();
    check("post-rst d1 icode", 64'(d1_icode), 64'h4);
    check("post-rst d1 valid", 64'(d1_valid), 64'h1);

    // Saturation of the 4-bit counter.
    do_reset();
    drive(2'b00, 4'h0, 64'h0, 4'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      step();
      check($sformatf("sat e%0d cnt", i), 64'(d3_cnt), 64'((i > 15) ? 15 : i));
    end
    check("sat d1 cnt", 64'(d1_cnt), 64'd20);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/m_pipe_reg.md
M_PIPE_REG -- requirements
Module: m_pipe_reg

Interface
REQ-001 SHALL have parameter WORD_W, default 64, width of valE/valA/valB.
REQ-002 SHALL have parameter REG_W, default 4, width of register IDs and icode.
REQ-003 SHALL have parameter DEPTH, default 1, legal 1..4, number of execute-to-memory register stages.
REQ-004 SHALL have parameter CNT_W, default 16, bubble counter width.
REQ-005 SHALL have parameter BUBBLE_ICODE, default 4'h1 (NOP), icode loaded by bubble or reset.
REQ-006 SHALL have parameter AOK, default 2'b00, status code meaning normal operation.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 e_stat  in  2  execute-stage status.
REQ-010 e_icode  in  REG_W  execute-stage instruction code.
REQ-011 e_Cnd  in  1  condition result.
REQ-012 e_valE, e_valA, e_valB  in  WORD_W each  datapath values.
REQ-013 e_dstE, e_dstM  in  REG_W each  destination register IDs.
REQ-014 M_stall  in  1  hold all stages.
REQ-015 M_bubble  in  1  inject NOP into stage 0 instead of e_* inputs.
REQ-016 M_stat, M_icode, M_Cnd, M_valE, M_valA, M_valB, M_dstE, M_dstM  out  widths as e_* counterparts  contents of last stage.
REQ-017 M_valid  out  1  last stage holds a real (non-bubble) instruction.
REQ-018 M_fault  out  1  sticky; last stage presented non-AOK status.
REQ-019 M_bubble_cnt  out  CNT_W  number of bubbles injected since reset.

Function
REQ-020 Stages S[0..DEPTH-1] SHALL each hold all e_* fields plus a valid bit; outputs SHALL be driven directly from S[DEPTH-1] registers.
REQ-021 Edge priority SHALL be: fault-hold > M_stall > M_bubble > normal advance.
REQ-022 Normal advance: S[0] <= e_* with valid=1; S[i] <= S[i-1] for i>0.
REQ-023 Bubble: S[0] <= bubble entry; S[i] <= S[i-1]; M_bubble_cnt increments.
REQ-024 Bubble entry SHALL be: stat=AOK, icode=BUBBLE_ICODE, Cnd=0, valE/valA/valB=0, dstE=dstM=all-ones (RNONE), valid=0.
REQ-025 Stall: all stages and M_bubble_cnt SHALL hold; M_bubble asserted with M_stall SHALL be ignored (no injection, no count).
REQ-026 Latency SHALL be exactly DEPTH rising edges from e_* sampled to M_* visible, excluding stalled edges.
REQ-027 M_fault SHALL set on the edge after M_stat != AOK is observed at the output, and SHALL remain 1 until rst.
REQ-028 While M_fault=1, all stages and M_bubble_cnt SHALL hold regardless of M_stall/M_bubble; the faulting entry stays on outputs.
REQ-029 M_bubble_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-030 No combinational path from any input to any output.

Reset
REQ-031 rst=1 SHALL immediately (without clk) load every stage with the bubble entry, clear M_fault and M_bubble_cnt to 0.
REQ-032 After reset: M_stat=AOK, M_icode=BUBBLE_ICODE, M_Cnd=0, M_val*=0, M_dstE=M_dstM=4'hF, M_valid=0.
REQ-033 rst asserted mid-stall, mid-bubble or mid-fault SHALL override all, and the first edge after release SHALL behave as normal advance.
REQ-034 Reset is not counted as a bubble.

Verification
REQ-035 DEPTH=1: e_icode=4'h6, e_valE=64'h10, e_dstE=4'h3 one edge -> M_icode=6, M_valE=0x10, M_dstE=3, M_valid=1 after that edge.
REQ-036 DEPTH=3: distinct icodes 2,3,4 on consecutive edges, M_stall high on edge 2 -> each appears at output 3 non-stalled edges later, order 2,3,4 preserved, no duplicates.
REQ-037 M_bubble pulse one edge with M_stall=0 -> output shows icode=1, dstE=dstM=F, M_valid=0 DEPTH edges later; M_bubble_cnt=1; same pulse with M_stall=1 -> M_bubble_cnt unchanged.
REQ-038 e_stat=2'b01 instruction, DEPTH=2 -> M_stat=01 after 2 edges, M_fault=1 next edge, outputs frozen for 10 further edges with new e_* inputs.
REQ-039 CNT_W=4, M_bubble held 20 edges -> M_bubble_cnt reaches 15 and stays 15.
REQ-040 rst asserted asynchronously between edges while M_fault=1 -> M_fault=0, M_valid=0, M_bubble_cnt=0 before next clk edge.
